// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - left-to-right square-and-multiply modular exponentiation sequencer
// Optional feature macro: MOD_EXP_SKIP_SQUARE_EN (skip squaring while the accumulator is still exactly 1).
module mod_exp_ctrl #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] mm_y,
    output logic [WIDTH-1:0] mm_z,
    output logic [WIDTH-1:0] mm_n,
    output logic             mm_ready,
    input  logic [WIDTH-1:0] mm_result,
    input  logic             mm_valid,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_BIT      = 3'd1;
    localparam logic [2:0] S_SQ_REQ   = 3'd2;
    localparam logic [2:0] S_SQ_WAIT  = 3'd3;
    localparam logic [2:0] S_MUL_REQ  = 3'd4;
    localparam logic [2:0] S_MUL_WAIT = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mm_y_q, mm_y_d;
    logic [WIDTH-1:0] mm_z_q, mm_z_d;
    logic [WIDTH-1:0] mm_n_q, mm_n_d;
`ifdef MOD_EXP_SKIP_SQUARE_EN
    logic             one_q, one_d;
`endif

    logic             adv;
    logic [WIDTH-1:0] r_adv;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        exp_d      = exp_q;
        mod_d      = mod_q;
        r_d        = r_q;
        idx_d      = idx_q;
        op_count_d = op_count_q;
        result_d   = result_q;
        mm_y_d     = mm_y_q;
        mm_z_d     = mm_z_q;
        mm_n_d     = mm_n_q;
`ifdef MOD_EXP_SKIP_SQUARE_EN
        one_d      = one_q;
`endif
        adv        = 1'b0;
        r_adv      = r_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base;
                    exp_d      = exponent;
                    mod_d      = modulus;
                    r_d        = {{(WIDTH-1){1'b0}}, 1'b1};
                    idx_d      = IDX_W'(WIDTH - 1);
                    op_count_d = '0;
`ifdef MOD_EXP_SKIP_SQUARE_EN
                    one_d      = 1'b1;
`endif
                    state_d    = S_BIT;
                end
            end
            S_BIT: begin
`ifdef MOD_EXP_SKIP_SQUARE_EN
                // While R is still 1 a square is a no-op, so go straight to the multiply or next bit.
                if (one_q && exp_q[idx_q]) begin
                    mm_y_d  = r_q;
                    mm_z_d  = base_q;
                    mm_n_d  = mod_q;
                    state_d = S_MUL_REQ;
                end else if (one_q) begin
                    adv = 1'b1;
                end else begin
                    mm_y_d  = r_q;
                    mm_z_d  = r_q;
                    mm_n_d  = mod_q;
                    state_d = S_SQ_REQ;
                end
`else
                mm_y_d  = r_q;
                mm_z_d  = r_q;
                mm_n_d  = mod_q;
                state_d = S_SQ_REQ;
`endif
            end
            S_SQ_REQ: begin
                op_count_d = op_count_q + CNT_W'(1);
                state_d    = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mm_valid) begin
                    r_d = mm_result;
`ifdef MOD_EXP_SKIP_SQUARE_EN
                    one_d = 1'b0;
`endif
                    if (exp_q[idx_q]) begin
                        mm_y_d  = mm_result;
                        mm_z_d  = base_q;
                        mm_n_d  = mod_q;
                        state_d = S_MUL_REQ;
                    end else begin
                        adv   = 1'b1;
                        r_adv = mm_result;
                    end
                end
            end
            S_MUL_REQ: begin
                op_count_d = op_count_q + CNT_W'(1);
                state_d    = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mm_valid) begin
                    r_d = mm_result;
`ifdef MOD_EXP_SKIP_SQUARE_EN
                    one_d = 1'b0;
`endif
                    adv   = 1'b1;
                    r_adv = mm_result;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result is captured on entry to FIN so it is already valid while done is high.
        if (adv) begin
            if (idx_q == '0) begin
                result_d = r_adv;
                state_d  = S_FIN;
            end else begin
                idx_d   = idx_q - IDX_W'(1);
                state_d = S_BIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            exp_q      <= '0;
            mod_q      <= '0;
            r_q        <= {{(WIDTH-1){1'b0}}, 1'b1};
            idx_q      <= '0;
            op_count_q <= '0;
            result_q   <= '0;
            mm_y_q     <= '0;
            mm_z_q     <= '0;
            mm_n_q     <= '0;
`ifdef MOD_EXP_SKIP_SQUARE_EN
            one_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            mod_q      <= mod_d;
            r_q        <= r_d;
            idx_q      <= idx_d;
            op_count_q <= op_count_d;
            result_q   <= result_d;
            mm_y_q     <= mm_y_d;
            mm_z_q     <= mm_z_d;
            mm_n_q     <= mm_n_d;
`ifdef MOD_EXP_SKIP_SQUARE_EN
            one_q      <= one_d;
`endif
        end
    end

    assign mm_ready = (state_q == S_SQ_REQ) || (state_q == S_MUL_REQ);
    assign done     = (state_q == S_FIN);
    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign mm_y     = mm_y_q;
    assign mm_z     = mm_z_q;
    assign mm_n     = mm_n_q;
    assign result   = result_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb/tb_mod_exp_ctrl.sv - randomized self-checking bench for mod_exp_ctrl with a modular multiplier model
module tb_mod_exp_ctrl;

    localparam int W     = 256;
    localparam int CW    = 10;
    localparam int BOUND = 8000;

    logic          clk = 1'b0;
    logic          reset, start, mm_ready, mm_valid, done, busy;
    logic [W-1:0]  base, exponent, modulus, mm_y, mm_z, mm_n, mm_result, result;
    logic [CW-1:0] op_count;

    int errors = 0;
    int checks = 0;
    int ready_pulses = 0;
    int done_cnt = 0;
    bit rsp_en = 1'b1;

    mod_exp_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base(base), .exponent(exponent), .modulus(modulus),
        .mm_y(mm_y), .mm_z(mm_z), .mm_n(mm_n), .mm_ready(mm_ready),
        .mm_result(mm_result), .mm_valid(mm_valid),
        .result(result), .done(done), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Right-to-left exponentiation: a different evaluation order from the DUT, same mathematical result.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                 input logic [W-1:0] n);
        logic [2*W-1:0] r, p, nn;
        nn = {{W{1'b0}}, n};
        r  = 1;
        p  = {{W{1'b0}}, b} % nn;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * p) % nn;
            p = (p * p) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic int ref_ops(input logic [W-1:0] e);
        int pc, msb;
        pc  = 0;
        msb = -1;
        for (int i = 0; i < W; i++) if (e[i]) begin pc++; msb = i; end
`ifdef MOD_EXP_SKIP_SQUARE_EN
        return (msb < 0) ? 0 : msb + pc;
`else
        return W + pc;
`endif
    endfunction

    task automatic serve();
        logic [W-1:0]   oy, oz, on;
        logic [2*W-1:0] prod;
        int lat;
        oy = mm_y; oz = mm_z; on = mm_n;
        ready_pulses++;
        lat = $urandom_range(0, 2);
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            checks++;
            if (mm_ready !== 1'b0) begin
                errors++;
                $display("FAIL mm_ready_outstanding: got %b required 0", mm_ready);
            end
            checks++;
            if (mm_y !== oy || mm_z !== oz || mm_n !== on) begin
                errors++;
                $display("FAIL operand_stable: y=%h z=%h n=%h required y=%h z=%h n=%h", mm_y, mm_z, mm_n, oy, oz, on);
            end
        end
        prod = ({{W{1'b0}}, oy} * {{W{1'b0}}, oz}) % {{W{1'b0}}, on};
        mm_result = prod[W-1:0];
        mm_valid  = 1'b1;
        @(posedge clk); #1;
        mm_valid  = 1'b0;
        mm_result = rand_w();
    endtask

    initial begin
        mm_valid  = 1'b0;
        mm_result = '0;
        forever begin
            @(posedge clk); #1;
            while (mm_ready === 1'b1 && rsp_en) serve();
        end
    end

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                          input bit repulse, input string tag);
        logic [W-1:0] exp_r;
        int exp_ops, d0;
        bit got;
        exp_r   = ref_modexp(b, e, n);
        exp_ops = ref_ops(e);
        @(negedge clk);
        base = b; exponent = e; modulus = n; start = 1'b1;
        ready_pulses = 0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        base = rand_w(); exponent = rand_w(); modulus = rand_w();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b required 1", tag, busy);
        end
        if (repulse) begin
            repeat (20) @(negedge clk);
            base = 5; exponent = 7; modulus = 11; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int cyc = 0; cyc < BOUND && !got; cyc++) begin
            if (done === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, BOUND);
        end else begin
            checks++;
            if (result !== exp_r) begin
                errors++;
                $display("FAIL %s result: got %h required %h", tag, result, exp_r);
            end
            checks++;
            if (int'(op_count) !== exp_ops) begin
                errors++;
                $display("FAIL %s op_count: got %0d required %0d", tag, op_count, exp_ops);
            end
            checks++;
            if (ready_pulses !== exp_ops) begin
                errors++;
                $display("FAIL %s ready_pulses: got %0d required %0d", tag, ready_pulses, exp_ops);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 !== 1) begin
                errors++;
                $display("FAIL %s single_done: done=%b busy=%b pulses=%0d required 0 0 1", tag, done, busy, done_cnt - d0);
            end
            checks++;
            if (result !== exp_r) begin
                errors++;
                $display("FAIL %s result_hold: got %h required %h", tag, result, exp_r);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mm_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b mm_ready=%b required 0 0 0", busy, done, mm_ready);
        end
        checks++;
        if (result !== '0 || op_count !== '0 || mm_y !== '0 || mm_z !== '0 || mm_n !== '0) begin
            errors++;
            $display("FAIL reset_data: result=%h op_count=%0d y=%h z=%h n=%h required all 0", result, op_count, mm_y, mm_z, mm_n);
        end
    endtask

    task automatic test_vectors();
        do_run(4, 13, 497, 1'b0, "v_4_13_497");
        checks++;
        if (result !== 445) begin errors++; $display("FAIL v_445: got %0d required 445", result); end
        do_run(600, 1, 497, 1'b0, "v_600_1_497");
        checks++;
        if (result !== 103) begin errors++; $display("FAIL v_103: got %0d required 103", result); end
        do_run(9, 0, 11, 1'b0, "v_e_zero");
        checks++;
        if (result !== 1) begin errors++; $display("FAIL v_e0: got %0d required 1", result); end
    endtask

    task automatic test_start_during_busy();
        do_run(2, 5, 13, 1'b1, "restart_ignored");
        checks++;
        if (result !== 6) begin errors++; $display("FAIL restart_result: got %0d required 6", result); end
    endtask

    task automatic test_abort();
        int d0;
        bit seen;
        rsp_en = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        base = 3; exponent = 4; modulus = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (mm_ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_no_request: no mm_ready within 50 cycles"); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || mm_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b mm_ready=%b done=%b required 0 0 0", busy, mm_ready, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL abort_done: got %0d pulses required 0", done_cnt - d0); end
        rsp_en = 1'b1;
        do_run(3, 4, 7, 1'b0, "after_abort");
        checks++;
        if (result !== 4) begin errors++; $display("FAIL abort_result: got %0d required 4", result); end
    endtask

    task automatic test_spurious_valid();
        logic [W-1:0] held;
        held = result;
        @(negedge clk);
        mm_result = rand_w(); mm_valid = 1'b1;
        @(negedge clk);
        mm_valid = 1'b0;
        checks++;
        if (result !== held || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: result=%h busy=%b required %h 0", result, busy, held);
        end
        do_run(rand_w(), 32'h0000_0b3d, 64'hffff_ffff_ffff_ffc5, 1'b0, "after_spurious");
    endtask

    task automatic test_random();
        logic [W-1:0] b, e, n;
        for (int t = 0; t < 5; t++) begin
            b = rand_w(); e = rand_w(); n = rand_w();
            if (t == 1) e = W'($urandom_range(1, 255));
            if (t == 2) begin n = W'($urandom_range(2, 1000)); b = n + W'($urandom_range(0, 5000)); end
            if (t == 3) e = {1'b1, {(W-1){1'b0}}};
            n[1] = 1'b1;
            do_run(b, e, n, 1'b0, $sformatf("random_%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_during_busy();
        test_abort();
        test_spurious_valid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 Parameter: WIDTH, 256, operand/exponent/modulus width; SHALL match the attached mul_mod datapath width.
REQ-002 Parameter: CNT_W, 10, width of op_count; SHALL hold WIDTH+WIDTH+1 without overflow at default.
REQ-003 Ports (SHALL be exactly):
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  start  in  1  one-cycle request to begin exponentiation
  base  in  WIDTH  b
  exponent  in  WIDTH  e
  modulus  in  WIDTH  n
  mm_y  out  WIDTH  multiplier operand y
  mm_z  out  WIDTH  multiplier operand z
  mm_n  out  WIDTH  multiplier modulus
  mm_ready  out  1  one-cycle multiplier start pulse
  mm_result  in  WIDTH  multiplier result M
  mm_valid  in  1  multiplier one-cycle completion pulse
  result  out  WIDTH  b^e mod n
  done  out  1  one-cycle completion pulse
  busy  out  1  high from start acceptance until done
  op_count  out  CNT_W  multiplier operations issued in last/current run

Function
REQ-004 Algorithm SHALL be left-to-right binary square-and-multiply over exponent bits WIDTH-1 down to 0, accumulator R initialised to 1.
REQ-005 States SHALL be IDLE, BIT, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, FIN.
REQ-006 IDLE: start=1 SHALL latch base, exponent, modulus, set R=1, bit index=WIDTH-1, op_count=0, busy=1, go BIT next cycle; start outside IDLE SHALL be ignored.
REQ-007 BIT: SHALL go SQ_REQ (square R*R) unless squaring skipped per REQ-019.
REQ-008 SQ_REQ/MUL_REQ: SHALL drive mm_ready=1 for exactly one cycle, increment op_count, go to matching WAIT.
REQ-009 mm_y, mm_z, mm_n SHALL be valid in the mm_ready cycle and held stable until mm_valid is sampled; square: y=z=R; multiply: y=R, z=latched base; n=latched modulus.
REQ-010 WAIT states SHALL hold until mm_valid=1, then load R<=mm_result; mm_result ignored when mm_valid=0.
REQ-011 After square: current bit=1 -> MUL_REQ; bit=0 -> advance. After multiply -> advance.
REQ-012 Advance: bit index 0 -> FIN; else decrement index, go BIT.
REQ-013 FIN: result<=R, done=1 for one cycle, busy=0, go IDLE; result and op_count SHALL hold until next accepted start.
REQ-014 mm_ready SHALL never assert while a multiplier operation is outstanding.
REQ-015 base>=n SHALL be accepted (first multiply reduces it); n<2 gives undefined result but SHALL still complete with done.
REQ-016 mm_valid arriving in any non-WAIT state SHALL be ignored.

Reset
REQ-017 reset SHALL take priority over all inputs; mid-operation reset SHALL abort to IDLE within one cycle with no done pulse.
REQ-018 Reset values: state=IDLE, mm_ready=0, done=0, busy=0, result=0, op_count=0, mm_y=mm_z=mm_n=0, R=1.

Configuration
REQ-019 Macro MOD_EXP_SKIP_SQUARE_EN: when defined, a flag "R is exactly 1" (set at start, cleared at first loaded mm_result) SHALL make BIT bypass SQ_REQ/SQ_WAIT while set, taking one cycle per bit, going directly to MUL_REQ on a 1 bit or advance on a 0 bit; e=0 then completes with result=1, op_count=0.
REQ-020 Without MOD_EXP_SKIP_SQUARE_EN: every bit SHALL issue a square; op_count = WIDTH + popcount(e); results identical in both builds for n>=2.

Verification
REQ-021 b=4, e=13, n=497 -> result=445; op_count=6 with macro, 259 without.
REQ-022 b=600, e=1, n=497 -> result=103; op_count=1 with macro, 257 without.
REQ-023 e=0, b=9, n=11 -> result=1, done one pulse; op_count=0 with macro, 256 without.
REQ-024 start pulsed again during busy (b=2, e=5, n=13) -> ignored; single done, result=6.
REQ-025 reset asserted while in SQ_WAIT -> next cycle busy=0, mm_ready=0, no done; new start b=3, e=4, n=7 -> result=4.
REQ-026 Every run: mm_ready pulses count = op_count, no two mm_ready without intervening mm_valid, operands stable across each operation.
